// File: rtl/msk_pipe.sv
// msk_pipe: masked elastic pipeline register with valid/ready handshake, flush and occupancy
module msk_pipe #(
  parameter int d = 2,
  parameter int count = 1,
  parameter int depth = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic [count*d-1:0]           in,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic [count*d-1:0]           out,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [$clog2(depth+1)-1:0]   occ
);
  localparam int w = count*d;
  localparam int ow = $clog2(depth+1);
  logic [depth-1:0] v, v_nx, ld, up;
  logic [depth:0] rdy;
  logic [w-1:0] s [depth];
  logic [w-1:0] ud [depth];
  logic [ow-1:0] cnt;
  // ready chain from the consumer back to stage 0, per-stage load and next valid
  always_comb begin
    rdy[depth] = out_ready & ~flush;
    up[0] = in_valid;
    ud[0] = in;
    for (int k = 1; k < depth; k++) begin
      up[k] = v[k-1];
      ud[k] = s[k-1];
    end
    cnt = '0;
    for (int k = depth-1; k >= 0; k--) begin
      rdy[k] = ~v[k] | rdy[k+1];
      ld[k] = rdy[k] & ~flush & up[k];
      v_nx[k] = flush ? 1'b0 : ld[k] | (v[k] & ~rdy[k]);
      cnt = cnt + ow'(v_nx[k]);
    end
  end
  // stage registers: share bits only move through flops and load muxes
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      v <= '0;
      occ <= '0;
      for (int k = 0; k < depth; k++) s[k] <= '0;
    end else begin
      v <= v_nx;
      occ <= cnt;
      for (int k = 0; k < depth; k++) if (ld[k]) s[k] <= ud[k];
    end
  assign in_ready = rdy[0] & ~flush;
  assign out = s[depth-1];
  assign out_valid = v[depth-1] & ~flush;
endmodule

// File: tb/tb_msk_pipe.sv
// tb_msk_pipe: directed vector bench for msk_pipe with d=3, count=2, depth=3
module tb_msk_pipe;
  logic clk = 1'b0, rst_n = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic in_ready, out_valid;
  logic [5:0] din = '0, dout;
  logic [1:0] occ;
  int total = 0, bad = 0;

  typedef struct {
    logic fl, iv;
    logic [5:0] din;
    logic ordy, irdy, ov;
    logic [5:0] dout;
    logic [1:0] occ;
  } vec_t;
  vec_t tv[$];

  msk_pipe #(.d(3), .count(2), .depth(3)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in(din), .in_valid(in_valid),
    .in_ready(in_ready), .out(dout), .out_valid(out_valid), .out_ready(out_ready), .occ(occ)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void add(input logic fl, iv, input logic [5:0] di, input logic ordy,
                              input logic irdy, ov, input logic [5:0] dout_e, input logic [1:0] occ_e);
    vec_t t;
    t.fl = fl; t.iv = iv; t.din = di; t.ordy = ordy;
    t.irdy = irdy; t.ov = ov; t.dout = dout_e; t.occ = occ_e;
    tv.push_back(t);
  endfunction

  initial begin
    int n;
    // stream 1..8, out_ready=1: 3-cycle latency, occ steady at 3
    add(0,1,6'h01,1, 1,0,6'h00,0);
    add(0,1,6'h02,1, 1,0,6'h00,1);
    add(0,1,6'h03,1, 1,0,6'h00,2);
    add(0,1,6'h04,1, 1,1,6'h01,3);
    add(0,1,6'h05,1, 1,1,6'h02,3);
    add(0,1,6'h06,1, 1,1,6'h03,3);
    add(0,1,6'h07,1, 1,1,6'h04,3);
    add(0,1,6'h08,1, 1,1,6'h05,3);
    add(0,0,6'h00,1, 1,1,6'h06,3);
    add(0,0,6'h00,1, 1,1,6'h07,2);
    add(0,0,6'h00,1, 1,1,6'h08,1);
    add(0,0,6'h00,0, 1,0,6'h08,0);
    // backpressure: 5 words offered, 3 accepted, then drain in order
    add(0,1,6'h11,0, 1,0,6'h08,0);
    add(0,1,6'h12,0, 1,0,6'h08,1);
    add(0,1,6'h13,0, 1,0,6'h08,2);
    add(0,1,6'h14,0, 0,1,6'h11,3);
    add(0,1,6'h14,0, 0,1,6'h11,3);
    add(0,1,6'h14,1, 1,1,6'h11,3);
    add(0,1,6'h15,1, 1,1,6'h12,3);
    add(0,0,6'h00,1, 1,1,6'h13,3);
    add(0,0,6'h00,1, 1,1,6'h14,2);
    add(0,0,6'h00,1, 1,1,6'h15,1);
    add(0,0,6'h00,0, 1,0,6'h15,0);
    // bubble compression with stalled tail
    add(0,1,6'h21,0, 1,0,6'h15,0);
    add(0,0,6'h00,0, 1,0,6'h15,1);
    add(0,0,6'h00,0, 1,0,6'h15,1);
    add(0,1,6'h22,0, 1,1,6'h21,1);
    add(0,0,6'h00,0, 1,1,6'h21,2);
    add(0,0,6'h00,0, 1,1,6'h21,2);
    add(0,1,6'h23,0, 1,1,6'h21,2);
    add(0,0,6'h00,0, 0,1,6'h21,3);
    // flush while full with both handshakes offered
    add(1,1,6'h24,1, 0,0,6'h21,3);
    add(0,0,6'h00,1, 1,0,6'h21,0);
    add(0,1,6'h25,0, 1,0,6'h21,0);
    add(0,0,6'h00,0, 1,0,6'h21,1);

    #2;
    chk("rst_out", dout, 6'h00);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_occ", occ, 0);
    chk("rst_in_ready", in_ready, 1);
    flush = 1'b1;
    #1 chk("rst_flush_in_ready", in_ready, 0);
    flush = 1'b0;
    @(negedge clk) rst_n = 1'b1;

    foreach (tv[i]) begin
      @(posedge clk); #1;
      flush = tv[i].fl; in_valid = tv[i].iv; din = tv[i].din; out_ready = tv[i].ordy;
      @(negedge clk);
      chk($sformatf("v%0d_in_ready", i), in_ready, tv[i].irdy);
      chk($sformatf("v%0d_out_valid", i), out_valid, tv[i].ov);
      chk($sformatf("v%0d_out", i), dout, tv[i].dout);
      chk($sformatf("v%0d_occ", i), occ, tv[i].occ);
    end

    // async reset between edges with a full pipe
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      flush = 1'b0; in_valid = 1'b1; din = 6'(8'h31 + k); out_ready = 1'b1;
    end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b0;
    #1;
    chk("pre_rst_out", dout, 6'h31);
    chk("pre_rst_occ", occ, 3);
    rst_n = 1'b0;
    #1;
    chk("arst_out", dout, 6'h00);
    chk("arst_out_valid", out_valid, 0);
    chk("arst_occ", occ, 0);
    chk("arst_in_ready", in_ready, 1);
    @(negedge clk) rst_n = 1'b1;

    // latency after release: word appears exactly 3 cycles after acceptance
    @(posedge clk); #1;
    in_valid = 1'b1; din = 6'h3a; out_ready = 1'b1;
    @(negedge clk) chk("lat_in_ready", in_ready, 1);
    n = 0;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      if (out_valid) begin
        n = c;
        break;
      end
    end
    chk("lat_cycles", n, 3);
    chk("lat_out", dout, 6'h3a);

    // share isolation: only bit 1 (share 1 of sharing 0) toggles, 3 cycles late
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      in_valid = 1'b1; out_ready = 1'b1; din = (c % 2 == 1) ? 6'b000010 : 6'b000000;
      @(negedge clk);
      if (c >= 3) chk($sformatf("iso%0d_out", c), dout, ((c - 3) % 2 == 1) ? 6'b000010 : 6'b000000);
    end
    in_valid = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/msk_pipe.md
# msk_pipe

Parametrised masked pipeline register with a valid/ready handshake. It carries `count` d-share sharings through `depth` register stages, with per-stage stalls, backpressure, a synchronous flush and an occupancy count. It replaces bare masked registers wherever a masked datapath needs elastic buffering between gadgets, for example between S-box layers or at the boundary with the unmasked control logic. Shares are only ever moved and held, never combined, so the block is affine with respect to the sharing.

## Interface
- `d`, 2: number of shares per sharing; must be ≥ 2.
- `count`, 1: number of independent sharings carried in parallel; must be ≥ 1.
- `depth`, 2: number of register stages; must be ≥ 1.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `flush` input 1: synchronous discard of all stored words.
- `in` input count*d: input sharings, packed as sharing-major with shares contiguous (bit `i*d+s` is share `s` of sharing `i`).
- `in_valid` input 1: `in` holds a word.
- `in_ready` output 1: stage 0 can accept a word this cycle.
- `out` output count*d: sharings of the last stage, same packing as `in`.
- `out_valid` output 1: the last stage holds a word.
- `out_ready` input 1: the consumer accepts `out` this cycle.
- `occ` output $clog2(depth+1): number of valid stages, 0..depth.

## Operation
- State per stage k (0..depth-1): `v[k]` (1 bit) and `s[k]` (count*d bits).
- Let `rdy[depth] = out_ready & ~flush` and `rdy[k] = ~v[k] | rdy[k+1]`.
- `in_ready = rdy[0] & ~flush`.
- `out = s[depth-1]`.
- `out_valid = v[depth-1] & ~flush`.
- Stage k loads when `rdy[k]` is high and its upstream is valid (`in_valid` for k = 0, `v[k-1]` for k > 0).
  - On load: `s[k]` takes the upstream data and `v[k]` is set.
  - Else, if `rdy[k]` is high, `v[k]` clears (the word left downstream). `s[k]` is not written.
  - Else (stalled): `s[k]` and `v[k]` hold.
- `s[k]` is written only on load. No stage mixes bits of different shares or different sharings. Each share bit passes only through flops and 2:1 load muxes.
- Flush: at the edge with `flush=1`, all `v[k]` clear and `s[k]` holds. No transfer occurs in the flush cycle on either port.
- Reset (`rst_n=0`, asynchronous): all `v[k]=0`, all `s[k]=0`. `in_ready=1` during and after reset unless `flush=1`.
- `occ` is the registered population count of `v`. It is updated at the same edge as `v`.
- `in_ready` has a combinational path from `out_ready` and `flush` through the `rdy` chain. There is no combinational path from `in_valid` or `in` to any output.

## Timing
- Reset values: `out=0`, `out_valid=0`, `occ=0`, `in_ready=~flush`.
- Latency: a word accepted at the edge ending cycle t is on `out` with `out_valid=1` in cycle t+depth when the pipe is empty and `out_ready=1`. For depth=1 this is a one-cycle masked register.
- Throughput: one word per cycle while `out_ready=1`. A stream never sees `in_ready` drop in steady state.
- Full: with all `v=1` and `out_ready=0`, `in_ready=0` and `occ=depth`. Everything holds.
- Full with simultaneous `out_ready=1` and `in_valid=1`: the output word leaves, every stage shifts and the new word enters in the same cycle. `occ` stays at depth.
- Bubbles: a stalled tail does not block upstream stages that hold `v=0`. Bubbles compress.
- `flush` together with `in_valid` or `out_ready`: the flush wins, nothing is transferred, and `occ=0` next cycle.
- Reset asserted mid-stream: state clears immediately and asynchronously. Words in flight are lost. Release is synchronised externally.

## Test plan
- Reset then stream, d=2, count=2, depth=3, `out_ready=1`: send words 0x1..0x8 on consecutive cycles → each appears at `out` exactly 3 cycles later, in order, with `out_valid` contiguous and `occ` steady at 3.
- Backpressure, depth=3: hold `out_ready=0` and offer 5 words → 3 are accepted, `in_ready=0` from the 4th, `occ=3`. Raise `out_ready` → remaining words drain in order with no loss or duplicate.
- Bubble compression, depth=4: insert a word, idle 2 cycles, insert a word with `out_ready=0` → both are held in stages 3 and 2, `occ=2`, `in_ready=1`.
- Flush with pipe full (`occ=3`) and `in_valid=1`, `out_ready=1` → no handshake in that cycle, `occ=0` and `out_valid=0` next cycle, `s` unchanged.
- Async reset mid-stream, depth=2: pull `rst_n` low between edges → `out=0`, `out_valid=0`, `occ=0` before the next edge. After release, a new word emerges 2 cycles after acceptance.
- Share isolation, d=3: drive a single toggling bit in share 1 of sharing 0 → only the corresponding `out` bit ever toggles, delayed by depth cycles.
